// File: rtl/cpu_pkg.sv
// Shared front-end constants and types: fetch FSM encoding, watchdog default,
// and the captured-instruction payload.
package cpu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_ins_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts unacknowledged request cycles and raises a sticky error once the
// count reaches TIMEOUT. The counter is zero whenever no request is waiting.
module fetch_watchdog
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rstd,
  input  logic req_active_i,
  input  logic ack_i,
  input  logic flush_i,
  output logic fetch_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             waiting;

  // Leaving REQ, an ack or a flush all zero the count, so REQ is always entered at 0.
  assign waiting = req_active_i & ~ack_i & ~flush_i;

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (waiting) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_d == LIMIT) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err_o = err_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request at pc, hold the returned word
// until decode accepts it, then request again with the updated pc.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        flush,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  fetch_ins_t   ins_q, ins_d;
  logic         in_req;
  logic         in_hold;

  assign in_req  = (state_q == ST_REQ);
  assign in_hold = (state_q == ST_HOLD);

  // Next-state and capture; flush always wins over a coincident ack.
  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (!flush && imem_ack) begin
          state_d = ST_HOLD;
          ins_d   = '{pc: pc, word: imem_rdata};
        end
      end
      ST_HOLD: begin
        if (flush || ins_ready) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= ST_IDLE;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
    end
  end

  assign imem_req  = in_req;
  assign imem_addr = in_req ? pc : '0;
  assign ins_valid = in_hold;
  assign pc_en     = in_hold & ins_ready & ~flush;
  assign ins       = ins_q.word;
  assign ins_pc    = ins_q.pc;

  fetch_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rstd        (rstd),
    .req_active_i(in_req),
    .ack_i       (imem_ack),
    .flush_i     (flush),
    .fetch_err_o (fetch_err)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a scoreboard of expected instructions.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rstd;
  logic [31:0] pc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        flush;
  logic        fetch_err;

  fetch_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rstd      (rstd),
    .pc        (pc),
    .pc_en     (pc_en),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ins       (ins),
    .ins_pc    (ins_pc),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .flush     (flush),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        flush;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_pc_en;
    logic        e_err;
  } vec_t;

  vec_t       tbl[$];
  fetch_ins_t sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] p, input logic a, input logic [31:0] rd,
                     input logic rdy, input logic fl, input logic er,
                     input logic [31:0] ea, input logic ev, input logic ep,
                     input logic ee);
    vec_t v;
    v.pc = p; v.ack = a; v.rdata = rd; v.ready = rdy; v.flush = fl;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc_en = ep; v.e_err = ee;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t       v;
    fetch_ins_t exp_ins;

    // pc, ack, rdata, ready, flush | req, addr, valid, pc_en, err
    add(32'h0, 1, 32'h8C220004, 0, 0, 1, 32'h0, 0, 0, 0);
    add(32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 1, 1, 0);
    add(32'h4, 1, 32'h00430820, 0, 0, 1, 32'h4, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(32'h4, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0);
    add(32'h4, 0, 32'h0, 1, 0, 0, 32'h0, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(32'h10, 0, 32'h0, 0, 0, 1, 32'h10, 0, 0, 0);
    add(32'h10, 1, 32'hAC450008, 0, 0, 1, 32'h10, 0, 0, 0);
    add(32'h10, 0, 32'h0, 1, 0, 0, 32'h0, 1, 1, 0);
    add(32'h14, 1, 32'hDEADBEEF, 0, 1, 1, 32'h14, 0, 0, 0);
    add(32'h14, 0, 32'h0, 0, 0, 1, 32'h14, 0, 0, 0);
    add(32'h14, 1, 32'h20010001, 0, 0, 1, 32'h14, 0, 0, 0);
    add(32'h14, 0, 32'h0, 1, 1, 0, 32'h0, 1, 0, 0);
    add(32'h14, 0, 32'h0, 0, 0, 1, 32'h14, 0, 0, 0);
    add(32'h14, 0, 32'h0, 0, 1, 1, 32'h14, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(32'h14, 0, 32'h0, 0, 0, 1, 32'h14, 0, 0, 0);
    for (int k = 0; k < 2; k++) add(32'h14, 0, 32'h0, 0, 0, 1, 32'h14, 0, 0, 1);
    add(32'h14, 1, 32'h3C01ABCD, 0, 0, 1, 32'h14, 0, 0, 1);
    add(32'h14, 0, 32'h0, 1, 0, 0, 32'h0, 1, 1, 1);
    add(32'h18, 1, 32'h11111111, 0, 0, 1, 32'h18, 0, 0, 1);
    add(32'h18, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 1);

    rstd = 1'b1; pc = '0; imem_ack = 1'b0; imem_rdata = '0; ins_ready = 1'b0; flush = 1'b0;
    #1 rstd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   32'(imem_req),  32'h0);
    chk("rst.addr",  imem_addr,      32'h0);
    chk("rst.valid", 32'(ins_valid), 32'h0);
    chk("rst.ins",   ins,            32'h0);
    chk("rst.inspc", ins_pc,         32'h0);
    chk("rst.err",   32'(fetch_err), 32'h0);
    rstd = 1'b1;
    #4;
    chk("idle.req", 32'(imem_req), 32'h0);

    foreach (tbl[i]) begin
      v = tbl[i];
      @(posedge clk);
      #1;
      pc = v.pc; imem_ack = v.ack; imem_rdata = v.rdata; ins_ready = v.ready; flush = v.flush;
      #4;
      chk($sformatf("r%0d.req", i),   32'(imem_req),  32'(v.e_req));
      chk($sformatf("r%0d.addr", i),  imem_addr,      v.e_addr);
      chk($sformatf("r%0d.valid", i), 32'(ins_valid), 32'(v.e_valid));
      chk($sformatf("r%0d.pc_en", i), 32'(pc_en),     32'(v.e_pc_en));
      chk($sformatf("r%0d.err", i),   32'(fetch_err), 32'(v.e_err));
      if (v.e_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL r%0d.sb: got empty scoreboard, want a held instruction", i);
        end else begin
          exp_ins = sb[0];
          chk($sformatf("r%0d.ins", i),   ins,    exp_ins.word);
          chk($sformatf("r%0d.inspc", i), ins_pc, exp_ins.pc);
          if (v.flush || v.ready) void'(sb.pop_front());
        end
      end
      if (v.e_req && v.ack && !v.flush) sb.push_back('{pc: v.pc, word: v.rdata});
    end

    // Asynchronous reset while holding an instruction.
    @(posedge clk);
    #2 ins_ready = 1'b1;
    #1 chk("hold.pc_en", 32'(pc_en), 32'h1);
    rstd = 1'b0;
    #1;
    chk("arst.valid", 32'(ins_valid), 32'h0);
    chk("arst.ins",   ins,            32'h0);
    chk("arst.inspc", ins_pc,         32'h0);
    chk("arst.pc_en", 32'(pc_en),     32'h0);
    chk("arst.req",   32'(imem_req),  32'h0);
    chk("arst.addr",  imem_addr,      32'h0);
    chk("arst.err",   32'(fetch_err), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    chk("arst2.valid", 32'(ins_valid), 32'h0);
    chk("arst2.req",   32'(imem_req),  32'h0);
    rstd = 1'b1; flush = 1'b1; pc = 32'h20; ins_ready = 1'b0;
    #4 chk("idle2.req", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1 flush = 1'b0;
    #4;
    chk("req2.req",  32'(imem_req),  32'h1);
    chk("req2.addr", imem_addr,      32'h20);
    chk("req2.err",  32'(fetch_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles imem_req may remain unacknowledged before fetch_err sets.
REQ-002 clk  input  1  SHALL be the single clock, with all state updated on its rising edge.
REQ-003 rstd  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 pc  input  32  SHALL carry the current program counter from the writeback PC register.
REQ-005 pc_en  output  1  SHALL permit the writeback stage to load nextpc at the next rising edge.
REQ-006 imem_req  output  1  SHALL request an instruction-memory read.
REQ-007 imem_addr  output  32  SHALL carry the read address.
REQ-008 imem_ack  input  1  SHALL indicate that imem_rdata is valid in the current cycle.
REQ-009 imem_rdata  input  32  SHALL carry the instruction word.
REQ-010 ins  output  32  SHALL carry the instruction word presented to decode.
REQ-011 ins_pc  output  32  SHALL carry the address of ins.
REQ-012 ins_valid  output  1  SHALL indicate that ins and ins_pc are valid.
REQ-013 ins_ready  input  1  SHALL indicate that decode accepts ins this cycle.
REQ-014 flush  input  1  SHALL discard any held or in-flight instruction.
REQ-015 fetch_err  output  1  SHALL be a sticky memory-timeout flag.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ and HOLD.
REQ-017 IDLE SHALL transition unconditionally to REQ on the first rising edge after reset release.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc (combinational); in all other states, imem_req SHALL be 0 and imem_addr SHALL be 0.
REQ-019 REQ with imem_ack=1 and flush=0 at a rising edge SHALL capture ins<=imem_rdata and ins_pc<=pc, and SHALL go to HOLD; the minimum request-to-valid latency SHALL be 1 cycle.
REQ-020 In HOLD, ins_valid SHALL be 1, and ins and ins_pc SHALL remain stable until accepted.
REQ-021 pc_en SHALL equal ins_valid AND ins_ready AND NOT flush (combinational); it SHALL be 1 for exactly the accepting cycle.
REQ-022 HOLD with ins_ready=1 and flush=0 SHALL go to REQ, so that the next request uses the updated pc in the following cycle.
REQ-023 flush=1 at a rising edge, in REQ or HOLD, SHALL force the FSM to REQ and ins_valid to 0; any coincident imem_ack SHALL be discarded.
REQ-024 flush=1 in IDLE SHALL have no effect beyond the normal IDLE-to-REQ transition.
REQ-025 A wait counter SHALL clear on entry to REQ, on imem_ack and on flush.
REQ-026 The wait counter SHALL increment each REQ cycle without imem_ack and SHALL saturate at TIMEOUT.
REQ-027 When the wait counter reaches TIMEOUT, fetch_err SHALL set to 1 and remain 1 until reset; the FSM SHALL stay in REQ and keep requesting.
REQ-028 A request SHALL not be committed before imem_ack, so dropping imem_req on flush SHALL be legal.
REQ-029 Throughput SHALL be at most one instruction per 2 cycles (REQ, HOLD); back-to-back overlap SHALL not be implemented.

Reset
REQ-030 rstd=0 SHALL asynchronously force: state=IDLE, ins=0, ins_pc=0, ins_valid=0, imem_req=0, imem_addr=0, pc_en=0, wait counter=0, fetch_err=0.
REQ-031 Assertion of rstd mid-request or mid-hold SHALL abandon the transaction with no further output activity until REQ is re-entered.
REQ-032 Deassertion of rstd SHALL take effect at the next rising edge of clk.

Structure
REQ-033 The FSM state encodings and the TIMEOUT default SHALL be defined as constants in the shared package cpu_pkg.
REQ-034 The wait counter and fetch_err logic SHALL be one sub-module, fetch_watchdog, parameterised by TIMEOUT.
REQ-035 Everything else SHALL reside in fetch_unit.

Verification
REQ-036 Reset, then pc=0x00000000, imem_ack=1 with rdata=0x8C220004 in the first REQ cycle -> ins_valid=1 in the next cycle with ins=0x8C220004 and ins_pc=0x0; ins_ready=1 -> pc_en=1 for one cycle.
REQ-037 HOLD with ins_ready=0 for 5 cycles -> ins, ins_pc and ins_valid stable; pc_en=0 throughout; imem_req=0.
REQ-038 imem_ack delayed 3 cycles with pc=0x00000010 -> imem_addr=0x10 held for 4 cycles; ins_pc=0x10 after ack; fetch_err=0.
REQ-039 flush coincident with imem_ack -> ins_valid stays 0 and the FSM re-enters REQ; flush in HOLD -> ins_valid=0 at the next edge and pc_en=0.
REQ-040 TIMEOUT=4 with no ack -> fetch_err=1 after 4 waiting cycles; a later ack delivers the instruction normally; fetch_err stays 1 until rstd=0.
REQ-041 rstd pulsed low during HOLD -> all outputs 0 immediately, asynchronously, without waiting for a clock edge.
